vga_value_display: RTL and testbench
====================================

// Module: vga_value_display
// PURPOSE
//   Parametrised multi-channel VGA value overlay: CHANNELS stacked rows, each showing a VALUE_WIDTH register
//   in binary (grouped, blank slot every GROUP digits) or hex. Values are written synchronously from data_mem.
//   Changed digits are highlighted for HILITE_FRAMES frames. Drives an external 1-cycle-latency glyph ROM and
//   the pixel stream to the VGA sync block.
// PARAMETERS
//   CHANNELS       4        number of displayed rows/registers
//   VALUE_WIDTH    32       bits per channel; multiple of 4 and of GROUP
//   GROUP          4        binary digits per group (a blank slot follows each group except the last)
//   GLYPH_W        16       glyph width in pixels
//   GLYPH_H        32       glyph height in pixels
//   ROW_PITCH      40       vertical pitch between channel rows (>= GLYPH_H)
//   ORIGIN_X/Y     64/64    top-left pixel of channel 0, digit slot 0
//   COORD_WIDTH    12       width of x/y
//   BIT_DEPTH      12       vga_rgb width
//   HILITE_FRAMES  30       highlight hold time in frames (1..255)
//   BG_COLOR/BOX_COLOR/FG_COLOR/HL_COLOR  12'h000/12'h222/12'hFFF/12'hF80  outside/box/digit/highlight colours
// PORTS
//   clk          in   1                  system clock
//   rst          in   1                  synchronous reset, active high
//   display_en   in   1                  pixel (x,y) is in the visible area
//   x, y         in   COORD_WIDTH        current pixel coordinate
//   frame_start  in   1                  one-cycle pulse at start of each frame
//   mode         in   1                  0 = binary, 1 = hex
//   wr_en        in   1                  write strobe from data_mem
//   wr_addr      in   clog2(CHANNELS)    target channel
//   wr_data      in   VALUE_WIDTH        value to display
//   glyph_code   out  4                  glyph select: 0-F (binary uses 0/1)
//   glyph_row    out  clog2(GLYPH_H)     row within glyph
//   glyph_col    out  clog2(GLYPH_W)     column within glyph
//   glyph_pixel  in   1                  ROM foreground bit, valid one cycle after glyph_* address
//   vga_rgb      out  BIT_DEPTH          pixel colour
// BEHAVIOUR
//   - Reset: all values, masks, hold counters, pipeline regs, glyph_* and vga_rgb = 0.
//   - Pipeline: x,y,display_en sampled at edge N; glyph_* + region/colour info registered at N+1;
//     glyph_pixel sampled and vga_rgb registered at N+2. Fixed 2-cycle latency, no stalls.
//   - Geometry: dx=x-ORIGIN_X, dy=y-ORIGIN_Y (x<ORIGIN_X or y<ORIGIN_Y -> outside); ch=dy/ROW_PITCH,
//     glyph_row=dy%ROW_PITCH; slot s=dx/GLYPH_W, glyph_col=dx%GLYPH_W.
//   - Binary: SLOTS=VALUE_WIDTH+VALUE_WIDTH/GROUP-1; s is blank when (s+1)%(GROUP+1)==0;
//     digit d=s-s/(GROUP+1); shows bit value[VALUE_WIDTH-1-d] (MSB leftmost). Hex: SLOTS=VALUE_WIDTH/4,
//     no blanks, digit d shows nibble value[VALUE_WIDTH-1-4d -: 4].
//   - Box = ch<CHANNELS and s<SLOTS. Outside box or display_en=0 at edge N -> BG_COLOR (0 when !display_en).
//     Inside box: blank slot or glyph_row>=GLYPH_H -> BOX_COLOR; else glyph_pixel ? (hl ? HL_COLOR : FG_COLOR)
//     : BOX_COLOR.
//   - Write: on wr_en with wr_addr<CHANNELS, value[wr_addr]<=wr_data; mask[wr_addr]<=old^wr_data; if mask
//     nonzero, hold[wr_addr]<=HILITE_FRAMES. Equal data: value unchanged, mask/hold untouched. wr_addr>=CHANNELS
//     ignored. A write at edge N is visible to pixels sampled at N+1 onward.
//   - Highlight: on frame_start, every nonzero hold decrements; reaching 0 clears that channel's mask.
//     hl = hold!=0 and mask bit of displayed digit set (hex: any of its 4 bits set).
//   - Simultaneous wr_en and frame_start on the same channel: write wins (hold reloads, no decrement);
//     other channels decrement normally.
//   - mode change takes effect on next sampled pixel; mode does not alter values or masks.
//   - Reset mid-frame: outputs 0 from the edge after rst; pipeline flushes, first valid pixel 2 cycles later.
// TESTING
//   1 reset, display_en=1, x=y=0 -> vga_rgb=BG_COLOR after 2 cycles; glyph_*=0.
//   2 write ch0=32'h8000_0001, binary, x=ORIGIN_X+4,y=ORIGIN_Y+4 -> glyph_code=1 at N+1; slot 4 -> BOX_COLOR.
//   3 hex mode, ch2=32'hDEAD_BEEF, pixel in slot 0 of row 2 -> glyph_code=4'hD; slot 7 -> 4'hF.
//   4 write ch1 5->7 -> bit1 digit HL_COLOR, bit0 FG_COLOR; after 30 frame_start pulses -> FG_COLOR.
//   5 wr_en+frame_start same cycle ch1 with hold=3 -> hold=30; rewrite same value -> hold keeps counting.
//   6 wr_addr=CHANNELS, or y beyond last row -> no state change / BG_COLOR; rst mid-line -> vga_rgb=0 next edge.

Source files
------------

// File: rtl/vga_value_display_if.sv
// Register write bus from data_mem into the value overlay.
interface vga_value_display_if #(
  parameter int CHANNELS    = 4,
  parameter int VALUE_WIDTH = 32
) ();
  localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [VALUE_WIDTH-1:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/vga_value_display.sv
// Multi-channel VGA register overlay: binary/hex digit rows with change highlighting.
// Fixed 2-cycle pixel pipeline: sample -> glyph address -> colour.
module vga_value_display #(
  parameter int CHANNELS      = 4,
  parameter int VALUE_WIDTH   = 32,
  parameter int GROUP         = 4,
  parameter int GLYPH_W       = 16,
  parameter int GLYPH_H       = 32,
  parameter int ROW_PITCH     = 40,
  parameter int ORIGIN_X      = 64,
  parameter int ORIGIN_Y      = 64,
  parameter int COORD_WIDTH   = 12,
  parameter int BIT_DEPTH     = 12,
  parameter int HILITE_FRAMES = 30,
  parameter logic [BIT_DEPTH-1:0] BG_COLOR  = 12'h000,
  parameter logic [BIT_DEPTH-1:0] BOX_COLOR = 12'h222,
  parameter logic [BIT_DEPTH-1:0] FG_COLOR  = 12'hFFF,
  parameter logic [BIT_DEPTH-1:0] HL_COLOR  = 12'hF80
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         display_en,
  input  logic [COORD_WIDTH-1:0]       x,
  input  logic [COORD_WIDTH-1:0]       y,
  input  logic                         frame_start,
  input  logic                         mode,
  vga_value_display_if.slave           wr_bus,
  output logic [3:0]                   glyph_code,
  output logic [$clog2(GLYPH_H)-1:0]   glyph_row,
  output logic [$clog2(GLYPH_W)-1:0]   glyph_col,
  input  logic                         glyph_pixel,
  output logic [BIT_DEPTH-1:0]         vga_rgb
);
  localparam int AW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RW        = $clog2(GLYPH_H);
  localparam int CW        = $clog2(GLYPH_W);
  localparam int SLOTS_BIN = VALUE_WIDTH + VALUE_WIDTH / GROUP - 1;
  localparam int SLOTS_HEX = VALUE_WIDTH / 4;
  localparam logic [7:0] HOLD_INIT = 8'(HILITE_FRAMES);

  typedef logic [COORD_WIDTH-1:0] coord_t;

  logic [VALUE_WIDTH-1:0] value_q [CHANNELS];
  logic [VALUE_WIDTH-1:0] mask_q  [CHANNELS];
  logic [7:0]             hold_q  [CHANNELS];

  // A write carrying changed data always beats the frame decrement on that channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        value_q[i] <= '0;
        mask_q[i]  <= '0;
        hold_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_bus.wr_en && wr_bus.wr_addr == AW'(i) && wr_bus.wr_data != value_q[i]) begin
          value_q[i] <= wr_bus.wr_data;
          mask_q[i]  <= value_q[i] ^ wr_bus.wr_data;
          hold_q[i]  <= HOLD_INIT;
        end else if (frame_start && hold_q[i] != 8'd0) begin
          hold_q[i] <= hold_q[i] - 8'd1;
          if (hold_q[i] == 8'd1) mask_q[i] <= '0;
        end
      end
    end
  end

  logic   s1_en, s1_mode;
  coord_t s1_x, s1_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_en   <= 1'b0;
      s1_mode <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
    end else begin
      s1_en   <= display_en;
      s1_mode <= mode;
      s1_x    <= x;
      s1_y    <= y;
    end
  end

  coord_t dx, dy, ch, slot, digit, row_full, bin_sh, hex_sh;
  logic [VALUE_WIDTH-1:0] cur_val, cur_mask;
  logic [7:0] cur_hold;
  logic       in_box, blank, tall, mask_hit;
  logic [3:0] code;

  always_comb begin
    dx       = s1_x - coord_t'(ORIGIN_X);
    dy       = s1_y - coord_t'(ORIGIN_Y);
    ch       = dy / coord_t'(ROW_PITCH);
    row_full = dy % coord_t'(ROW_PITCH);
    slot     = dx / coord_t'(GLYPH_W);
    in_box   = s1_en && s1_x >= coord_t'(ORIGIN_X) && s1_y >= coord_t'(ORIGIN_Y) &&
               ch < coord_t'(CHANNELS) &&
               slot < (s1_mode ? coord_t'(SLOTS_HEX) : coord_t'(SLOTS_BIN));
    blank    = !s1_mode && ((slot + coord_t'(1)) % coord_t'(GROUP + 1)) == '0;
    tall     = row_full >= coord_t'(GLYPH_H);
    digit    = s1_mode ? slot : slot - slot / coord_t'(GROUP + 1);
    cur_val  = '0;
    cur_mask = '0;
    cur_hold = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch == coord_t'(i)) begin
        cur_val  = value_q[i];
        cur_mask = mask_q[i];
        cur_hold = hold_q[i];
      end
    end
    bin_sh   = coord_t'(VALUE_WIDTH - 1) - digit;
    hex_sh   = coord_t'(VALUE_WIDTH - 4) - (digit << 2);
    code     = s1_mode ? 4'(cur_val >> hex_sh) : {3'b000, 1'(cur_val >> bin_sh)};
    mask_hit = s1_mode ? (4'(cur_mask >> hex_sh) != 4'd0) : 1'(cur_mask >> bin_sh);
  end

  logic s2_en, s2_box, s2_fill, s2_hl;

  always_ff @(posedge clk) begin
    if (rst) begin
      glyph_code <= '0;
      glyph_row  <= '0;
      glyph_col  <= '0;
      s2_en      <= 1'b0;
      s2_box     <= 1'b0;
      s2_fill    <= 1'b0;
      s2_hl      <= 1'b0;
    end else begin
      glyph_code <= (in_box && !blank) ? code : 4'd0;
      glyph_row  <= in_box ? RW'(row_full) : '0;
      glyph_col  <= in_box ? CW'(dx % coord_t'(GLYPH_W)) : '0;
      s2_en      <= s1_en;
      s2_box     <= in_box;
      s2_fill    <= blank || tall;
      s2_hl      <= cur_hold != 8'd0 && mask_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               vga_rgb <= '0;
    else if (!s2_en)       vga_rgb <= '0;
    else if (!s2_box)      vga_rgb <= BG_COLOR;
    else if (s2_fill)      vga_rgb <= BOX_COLOR;
    else if (glyph_pixel)  vga_rgb <= s2_hl ? HL_COLOR : FG_COLOR;
    else                   vga_rgb <= BOX_COLOR;
  end
endmodule

// File: tb/tb_vga_value_display.sv
// Bench for vga_value_display: directed scenarios then random writes/frames/pixels vs a reference model.
module tb_vga_value_display;
  localparam int CH = 3, VW = 32, G = 4, GW = 16, GH = 32, RP = 40, OX = 64, OY = 64, HF = 30;
  localparam int SB = VW + VW / G - 1, SH = VW / 4;
  localparam logic [11:0] BG = 12'h000, BOX = 12'h222, FG = 12'hFFF, HL = 12'hF80;

  logic        clk = 1'b0;
  logic        rst, display_en, frame_start, mode, glyph_pixel;
  logic [11:0] x, y, vga_rgb;
  logic [3:0]  glyph_code, glyph_col;
  logic [4:0]  glyph_row;

  vga_value_display_if #(.CHANNELS(CH), .VALUE_WIDTH(VW)) bus ();

  vga_value_display #(.CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .display_en(display_en), .x(x), .y(y),
    .frame_start(frame_start), .mode(mode), .wr_bus(bus),
    .glyph_code(glyph_code), .glyph_row(glyph_row), .glyph_col(glyph_col),
    .glyph_pixel(glyph_pixel), .vga_rgb(vga_rgb)
  );

  always #5 clk = ~clk;

  logic [31:0] m_val [CH];
  logic [31:0] m_mask[CH];
  int          m_hold[CH];
  int n_cmp = 0, n_err = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < CH; i++) begin
      m_val[i] = '0; m_mask[i] = '0; m_hold[i] = 0;
    end
  endfunction

  // Expected glyph address and colour attributes for a pixel, straight from the layout rules.
  function automatic void model_pix(int px, int py, bit md, output logic [12:0] g,
                                    output bit inbox, output bit fill, output bit hl);
    int dx, dy, c, s, row, col, slots, d, code, sh;
    bit blank;
    g = '0; inbox = 0; fill = 0; hl = 0;
    if (px < OX || py < OY) return;
    dx = px - OX; dy = py - OY;
    c = dy / RP; row = dy % RP; s = dx / GW; col = dx % GW;
    slots = md ? SH : SB;
    if (c >= CH || s >= slots) return;
    inbox = 1;
    if (md) begin
      blank = 0; sh = VW - 4 - 4 * s;
      code = int'((m_val[c] >> sh) & 32'hF);
      hl = m_hold[c] != 0 && ((m_mask[c] >> sh) & 32'hF) != 0;
    end else begin
      blank = ((s + 1) % (G + 1)) == 0;
      d = s - s / (G + 1); sh = VW - 1 - d;
      code = blank ? 0 : int'((m_val[c] >> sh) & 32'h1);
      hl = m_hold[c] != 0 && ((m_mask[c] >> sh) & 32'h1) != 0;
    end
    fill = blank || row >= GH;
    g = {4'(code), 5'(row), 4'(col)};
  endfunction

  task automatic pixel(string tag, int px, int py, bit md, bit en, bit gp);
    logic [12:0] g;
    logic [11:0] rgb;
    bit inbox, fill, hl;
    @(negedge clk);
    x = 12'(px); y = 12'(py); mode = md; display_en = en;
    model_pix(px, py, md, g, inbox, fill, hl);
    if (!en) begin g = '0; rgb = 12'h000; end
    else if (!inbox) rgb = BG;
    else if (fill) rgb = BOX;
    else if (gp) rgb = hl ? HL : FG;
    else rgb = BOX;
    @(posedge clk);
    @(negedge clk);
    display_en = 1'b0; x = '0; y = '0;
    @(posedge clk); #1;
    check({tag, "_glyph"}, 32'({glyph_code, glyph_row, glyph_col}), 32'(g));
    glyph_pixel = gp;
    @(posedge clk); #1;
    check({tag, "_rgb"}, 32'(vga_rgb), 32'(rgb));
    glyph_pixel = 1'b0;
  endtask

  task automatic step(bit we, int a, logic [31:0] d, bit fs);
    @(negedge clk);
    bus.wr_en = we; bus.wr_addr = 2'(a); bus.wr_data = d; frame_start = fs;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; frame_start = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (we && a == i && d != m_val[i]) begin
        m_mask[i] = m_val[i] ^ d; m_val[i] = d; m_hold[i] = HF;
      end else if (fs && m_hold[i] > 0) begin
        m_hold[i]--;
        if (m_hold[i] == 0) m_mask[i] = '0;
      end
    end
  endtask

  task automatic frames(int n);
    repeat (n) step(1'b0, 0, 32'h0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rgb", 32'(vga_rgb), 32'h0);
    check("rst_glyph", 32'({glyph_code, glyph_row, glyph_col}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int px, py, a, r;
    logic [31:0] d;
    rst = 1'b0; display_en = 1'b0; frame_start = 1'b0; mode = 1'b0; glyph_pixel = 1'b0;
    x = '0; y = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    model_clear();

    do_reset();
    pixel("t1_origin", 0, 0, 0, 1, 1);

    step(1, 0, 32'h8000_0001, 0);
    pixel("t2_msb", OX + 4, OY + 4, 0, 1, 1);
    pixel("t2_blank", OX + 4 * GW + 4, OY + 4, 0, 1, 1);
    pixel("t2_lsb", OX + 38 * GW + 2, OY + 10, 0, 1, 1);

    step(1, 2, 32'hDEAD_BEEF, 0);
    pixel("t3_hex0", OX + 3, OY + 2 * RP + 5, 1, 1, 1);
    pixel("t3_hex7", OX + 7 * GW + 3, OY + 2 * RP + 5, 1, 1, 0);
    pixel("t3_hex8", OX + 8 * GW + 3, OY + 2 * RP + 5, 1, 1, 1);

    frames(30);
    step(1, 1, 32'h5, 0);
    frames(30);
    step(1, 1, 32'h7, 0);
    pixel("t4_bit1_hl", OX + 37 * GW + 5, OY + RP + 6, 0, 1, 1);
    pixel("t4_bit0_fg", OX + 38 * GW + 5, OY + RP + 6, 0, 1, 1);
    frames(29);
    pixel("t4_hold29", OX + 37 * GW + 5, OY + RP + 6, 0, 1, 1);
    frames(1);
    pixel("t4_expired", OX + 37 * GW + 5, OY + RP + 6, 0, 1, 1);

    step(1, 1, 32'h3, 0);
    frames(27);
    step(1, 1, 32'h1, 1);
    frames(29);
    pixel("t5_reload", OX + 37 * GW + 5, OY + RP + 6, 0, 1, 1);
    step(1, 1, 32'h1, 1);
    pixel("t5_samewr", OX + 37 * GW + 5, OY + RP + 6, 0, 1, 1);

    step(1, 3, 32'hFFFF_FFFF, 0);
    pixel("t6_badaddr0", OX + 2, OY + 2, 1, 1, 1);
    pixel("t6_badaddr1", OX + 4 * GW + 2, OY + RP + 2, 1, 1, 1);
    pixel("t6_below", OX + 4, OY + CH * RP + 4, 0, 1, 1);
    pixel("t6_gap", OX + 4, OY + 35, 0, 1, 1);
    pixel("t6_right", OX + SB * GW + 1, OY + 4, 0, 1, 1);
    pixel("t6_disabled", OX + 4, OY + 4, 0, 0, 1);

    @(negedge clk);
    x = 12'(OX + 2); y = 12'(OY + 2); mode = 1'b1; display_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_midrst_rgb", 32'(vga_rgb), 32'h0);
    check("t6_midrst_glyph", 32'({glyph_code, glyph_row, glyph_col}), 32'h0);
    @(negedge clk);
    rst = 1'b0; display_en = 1'b0;
    model_clear();
    pixel("t6_postrst", OX + 2, OY + 2, 1, 1, 1);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 3));
      if (r <= 1) begin
        a = int'($urandom_range(0, 3));
        case ($urandom_range(0, 2))
          0: d = $urandom();
          1: d = (a < CH) ? m_val[a] : 32'h0;
          default: d = ((a < CH) ? m_val[a] : 32'h0) ^ (32'h1 << $urandom_range(0, 31));
        endcase
        step(1, a, d, 1'($urandom_range(0, 1)));
      end else if (r == 2) begin
        frames(int'($urandom_range(1, 8)));
      end
      px = int'($urandom_range(0, OX + SB * GW + 30));
      py = int'($urandom_range(0, OY + CH * RP + 20));
      pixel("rand", px, py, 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
            1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
